// File: rtl/system_rst_seq.sv
// system_rst_seq: ordered multi-channel reset sequencer gated on memory
// calibration, with a latched fault state and software channel pulses.
module system_rst_seq #(
  parameter int NUM_CH      = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STEP_DELAY  = 16,
  parameter int CAL_TIMEOUT = 1048576
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_rstn,
  input  logic              cal_done,
  input  logic              cal_fail,
  input  logic              sw_req_valid,
  input  logic [NUM_CH-1:0] sw_req_mask,
  output logic              sw_req_ready,
  output logic [NUM_CH-1:0] rstn,
  output logic              seq_done,
  output logic              fault,
  output logic [2:0]        state
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int SW = (STEP_DELAY > 1) ? $clog2(STEP_DELAY) : 1;
  localparam int TW = $clog2(CAL_TIMEOUT) + 1;
  localparam int IW = $clog2(NUM_CH + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DELAY - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(CAL_TIMEOUT);
  localparam logic [IW-1:0] IDX_END   = IW'(NUM_CH);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_WAIT  = 3'd1,
    S_REL   = 3'd2,
    S_DONE  = 3'd3,
    S_PULSE = 3'd4,
    S_FAULT = 3'd5
  } state_e;

  logic [1:0]        sync_q;
  logic [1:0]        prime_q;
  logic              ext_low;
  logic              cal_bad;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] rstn_q, rstn_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [SW-1:0]     step_q, step_d;
  logic [TW-1:0]     to_q, to_d;
  logic [IW-1:0]     idx_q, idx_d;

  // The synchroniser's cleared value is not a real request: ignore it
  // until both stages have been loaded from ext_rstn.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      prime_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], ext_rstn};
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  assign ext_low = prime_q[1] & ~sync_q[1];
  assign cal_bad = cal_fail | ~cal_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      rstn_q  <= '0;
      hold_q  <= '0;
      step_q  <= '0;
      to_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rstn_q  <= rstn_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
      to_q    <= to_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rstn_d  = rstn_q;
    hold_d  = hold_q;
    step_d  = step_q;
    to_d    = to_q;
    idx_d   = idx_q;
    if (ext_low) begin
      state_d = S_RESET;
      rstn_d  = '0;
      hold_d  = '0;
      step_d  = '0;
      to_d    = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_RESET: begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_WAIT;
            hold_d  = '0;
            to_d    = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        S_WAIT: begin
          if (cal_fail) begin
            state_d = S_FAULT;
            rstn_d  = '0;
          end else if (cal_done) begin
            state_d = S_REL;
            step_d  = '0;
            idx_d   = '0;
          end else if (to_q >= TO_LIMIT) begin
            state_d = S_FAULT;
            rstn_d  = '0;
          end else if (to_q != '1) begin
            to_d = to_q + TW'(1);
          end
        end
        S_REL: begin
          if (cal_bad) begin
            state_d = S_FAULT;
            rstn_d  = '0;
          end else if (idx_q == IDX_END) begin
            state_d = S_DONE;
          end else if (step_q == STEP_LAST) begin
            rstn_d = rstn_q | (NUM_CH'(1) << idx_q);
            idx_d  = idx_q + IW'(1);
            step_d = '0;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
        S_DONE: begin
          if (cal_bad) begin
            state_d = S_FAULT;
            rstn_d  = '0;
          end else if (sw_req_valid && (sw_req_mask != '0)) begin
            state_d = S_PULSE;
            rstn_d  = rstn_q & ~sw_req_mask;
            hold_d  = '0;
          end
        end
        S_PULSE: begin
          if (cal_bad) begin
            state_d = S_FAULT;
            rstn_d  = '0;
          end else if (hold_q == HOLD_LAST) begin
            state_d = S_DONE;
            rstn_d  = '1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        S_FAULT: begin
          rstn_d = '0;
        end
        default: begin
          state_d = S_RESET;
          rstn_d  = '0;
        end
      endcase
    end
  end

  assign rstn         = rstn_q;
  assign state        = state_q;
  assign seq_done     = (state_q == S_DONE);
  assign fault        = (state_q == S_FAULT);
  assign sw_req_ready = (state_q == S_DONE);

endmodule

// File: tb/tb_system_rst_seq.sv
// tb_system_rst_seq: vector table, hand-written corner sequences and a
// randomized run against a timestamp-based reference model.
module tb_system_rst_seq;

  localparam int NCH  = 4;
  localparam int HOLD = 8;
  localparam int STEP = 16;

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_REL   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_PULSE = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_ext, a_cd, a_cf, a_v;
  logic [3:0] a_mask;
  logic       a_rdy, a_done, a_flt;
  logic [3:0] a_rstn;
  logic [2:0] a_st;

  logic       b_rst, b_ext, b_cd, b_cf, b_v;
  logic [0:0] b_mask;
  logic       b_rdy, b_done, b_flt;
  logic [0:0] b_rstn;
  logic [2:0] b_st;

  system_rst_seq #(
    .NUM_CH(4), .HOLD_CYCLES(8), .STEP_DELAY(16), .CAL_TIMEOUT(1048576)
  ) u_a (
    .clk(clk), .rst(a_rst), .ext_rstn(a_ext),
    .cal_done(a_cd), .cal_fail(a_cf),
    .sw_req_valid(a_v), .sw_req_mask(a_mask), .sw_req_ready(a_rdy),
    .rstn(a_rstn), .seq_done(a_done), .fault(a_flt), .state(a_st)
  );

  system_rst_seq #(
    .NUM_CH(1), .HOLD_CYCLES(8), .STEP_DELAY(1), .CAL_TIMEOUT(64)
  ) u_b (
    .clk(clk), .rst(b_rst), .ext_rstn(b_ext),
    .cal_done(b_cd), .cal_fail(b_cf),
    .sw_req_valid(b_v), .sw_req_mask(b_mask), .sw_req_ready(b_rdy),
    .rstn(b_rstn), .seq_done(b_done), .fault(b_flt), .state(b_st)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic adv(input int target);
    while (cyc < target) step();
  endtask

  task automatic chk_a(input string nm, input logic [3:0] r,
                       input logic d, input logic f, input logic [2:0] s);
    chk({nm, ".rstn"},  32'(a_rstn), 32'(r));
    chk({nm, ".done"},  32'(a_done), 32'(d));
    chk({nm, ".fault"}, 32'(a_flt),  32'(f));
    chk({nm, ".state"}, 32'(a_st),   32'(s));
    chk({nm, ".ready"}, 32'(a_rdy),  32'(s == ST_DONE));
  endtask

  task automatic chk_b(input string nm, input logic r,
                       input logic d, input logic f, input logic [2:0] s);
    chk({nm, ".rstn"},  32'(b_rstn), 32'(r));
    chk({nm, ".done"},  32'(b_done), 32'(d));
    chk({nm, ".fault"}, 32'(b_flt),  32'(f));
    chk({nm, ".state"}, 32'(b_st),   32'(s));
  endtask

  task automatic reset_a(input logic cd);
    a_rst = 1'b1; a_ext = 1'b1; a_cd = cd; a_cf = 1'b0;
    a_v = 1'b0; a_mask = '0;
    step(); step();
    a_rst = 1'b0;
    cyc = 0;
  endtask

  task automatic reset_b(input logic cd);
    b_rst = 1'b1; b_ext = 1'b1; b_cd = cd; b_cf = 1'b0;
    b_v = 1'b0; b_mask = '0;
    step(); step();
    b_rst = 1'b0;
    cyc = 0;
  endtask

  typedef struct {
    int         run;
    int         cal_on;
    int         cyc;
    logic [3:0] rstn;
    logic       done;
    logic       flt;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[$];

  // Reference model: phase plus entry timestamps; outputs follow from
  // elapsed time rather than from per-cycle counters.
  logic [2:0] m_ph;
  int         m_enter;
  int         m_quiet;
  logic [3:0] m_mask;
  logic       eh[$];

  function automatic logic [3:0] m_rstn(input int t);
    logic [3:0] r;
    r = '0;
    if (m_ph == ST_REL) begin
      for (int k = 0; k < NCH; k++) r[k] = (t >= m_enter + (k + 1) * STEP);
    end else if (m_ph == ST_DONE) begin
      r = '1;
    end else if (m_ph == ST_PULSE) begin
      r = ~m_mask;
    end
    return r;
  endfunction

  task automatic m_step(input int t, input logic cd, input logic cf,
                        input logic v, input logic [3:0] mk);
    logic elow;
    logic bad;
    elow = (t >= 2) && (eh[t-2] == 1'b0);
    bad  = cf || !cd;
    if (elow) begin
      m_ph    = ST_RESET;
      m_quiet = t + 1;
    end else begin
      case (m_ph)
        ST_RESET: if (t - m_quiet == HOLD - 1) begin
          m_ph = ST_WAIT; m_enter = t + 1;
        end
        ST_WAIT: if (cf) m_ph = ST_FAULT;
          else if (cd) begin m_ph = ST_REL; m_enter = t + 1; end
          else if (t - m_enter >= 1048576) m_ph = ST_FAULT;
        ST_REL: if (bad) m_ph = ST_FAULT;
          else if (t >= m_enter + NCH * STEP) m_ph = ST_DONE;
        ST_DONE: if (bad) m_ph = ST_FAULT;
          else if (v && mk != 4'h0) begin
            m_ph = ST_PULSE; m_mask = mk; m_enter = t + 1;
          end
        ST_PULSE: if (bad) m_ph = ST_FAULT;
          else if (t == m_enter + HOLD - 1) m_ph = ST_DONE;
        default: ;
      endcase
    end
  endtask

  initial begin
    int cur_run;
    int ext_left;
    a_rst = 1'b1; a_ext = 1'b1; a_cd = 1'b0; a_cf = 1'b0;
    a_v = 1'b0; a_mask = '0;
    b_rst = 1'b1; b_ext = 1'b1; b_cd = 1'b0; b_cf = 1'b0;
    b_v = 1'b0; b_mask = '0;

    tbl.push_back('{0, 0,   0, 4'h0, 1'b0, 1'b0, ST_RESET});
    tbl.push_back('{0, 0,   7, 4'h0, 1'b0, 1'b0, ST_RESET});
    tbl.push_back('{0, 0,   8, 4'h0, 1'b0, 1'b0, ST_WAIT});
    tbl.push_back('{0, 0,   9, 4'h0, 1'b0, 1'b0, ST_REL});
    tbl.push_back('{0, 0,  24, 4'h0, 1'b0, 1'b0, ST_REL});
    tbl.push_back('{0, 0,  25, 4'h1, 1'b0, 1'b0, ST_REL});
    tbl.push_back('{0, 0,  40, 4'h1, 1'b0, 1'b0, ST_REL});
    tbl.push_back('{0, 0,  41, 4'h3, 1'b0, 1'b0, ST_REL});
    tbl.push_back('{0, 0,  56, 4'h3, 1'b0, 1'b0, ST_REL});
    tbl.push_back('{0, 0,  57, 4'h7, 1'b0, 1'b0, ST_REL});
    tbl.push_back('{0, 0,  72, 4'h7, 1'b0, 1'b0, ST_REL});
    tbl.push_back('{0, 0,  73, 4'hF, 1'b0, 1'b0, ST_REL});
    tbl.push_back('{0, 0,  74, 4'hF, 1'b1, 1'b0, ST_DONE});
    tbl.push_back('{1, 100, 8, 4'h0, 1'b0, 1'b0, ST_WAIT});
    tbl.push_back('{1, 100, 60, 4'h0, 1'b0, 1'b0, ST_WAIT});
    tbl.push_back('{1, 100, 100, 4'h0, 1'b0, 1'b0, ST_WAIT});
    tbl.push_back('{1, 100, 101, 4'h0, 1'b0, 1'b0, ST_REL});
    tbl.push_back('{1, 100, 116, 4'h0, 1'b0, 1'b0, ST_REL});
    tbl.push_back('{1, 100, 117, 4'h1, 1'b0, 1'b0, ST_REL});

    cur_run = -1;
    foreach (tbl[i]) begin
      if (tbl[i].run != cur_run) begin
        cur_run = tbl[i].run;
        reset_a(1'b0);
        a_cd = (tbl[i].cal_on == 0);
      end
      while (cyc < tbl[i].cyc) begin
        step();
        a_cd = (cyc >= tbl[i].cal_on);
      end
      chk_a("tbl", tbl[i].rstn, tbl[i].done, tbl[i].flt, tbl[i].st);
    end

    // cal_fail after rstn[1], then ext_rstn low for 1 us and restart
    reset_a(1'b1);
    adv(45);
    chk_a("relfail_pre", 4'h3, 1'b0, 1'b0, ST_REL);
    a_cf = 1'b1;
    step();
    a_cf = 1'b0;
    chk_a("relfail", 4'h0, 1'b0, 1'b1, ST_FAULT);
    adv(50);
    chk_a("fault_hold", 4'h0, 1'b0, 1'b1, ST_FAULT);
    a_ext = 1'b0;
    adv(52);
    chk_a("ext_sync2", 4'h0, 1'b0, 1'b1, ST_FAULT);
    step();
    chk_a("ext_clear", 4'h0, 1'b0, 1'b0, ST_RESET);
    adv(150);
    a_ext = 1'b1;
    adv(159);
    chk_a("rs_reset", 4'h0, 1'b0, 1'b0, ST_RESET);
    step();
    chk_a("rs_wait", 4'h0, 1'b0, 1'b0, ST_WAIT);
    step();
    chk_a("rs_rel", 4'h0, 1'b0, 1'b0, ST_REL);
    adv(176);
    chk_a("rs_ch0_pre", 4'h0, 1'b0, 1'b0, ST_REL);
    step();
    chk_a("rs_ch0", 4'h1, 1'b0, 1'b0, ST_REL);
    adv(225);
    chk_a("rs_ch3", 4'hF, 1'b0, 1'b0, ST_REL);
    step();
    chk_a("rs_done", 4'hF, 1'b1, 1'b0, ST_DONE);

    // software pulse, then zero-mask no-op
    adv(230);
    a_v = 1'b1; a_mask = 4'b0101;
    chk_a("sw_idle", 4'hF, 1'b1, 1'b0, ST_DONE);
    step();
    a_v = 1'b0; a_mask = '0;
    for (int i = 0; i < HOLD; i++) begin
      chk_a("sw_pulse", 4'b1010, 1'b0, 1'b0, ST_PULSE);
      step();
    end
    chk_a("sw_end", 4'hF, 1'b1, 1'b0, ST_DONE);
    step();
    a_v = 1'b1; a_mask = 4'b0000;
    step();
    a_v = 1'b0;
    chk_a("sw_zero", 4'hF, 1'b1, 1'b0, ST_DONE);
    step();
    chk_a("sw_zero2", 4'hF, 1'b1, 1'b0, ST_DONE);

    // ext_rstn reaches the FSM on the same edge as a software accept
    adv(245);
    a_ext = 1'b0;
    chk_a("ea_0", 4'hF, 1'b1, 1'b0, ST_DONE);
    step();
    chk_a("ea_1", 4'hF, 1'b1, 1'b0, ST_DONE);
    step();
    a_v = 1'b1; a_mask = 4'hF;
    chk_a("ea_2", 4'hF, 1'b1, 1'b0, ST_DONE);
    step();
    a_v = 1'b0; a_mask = '0;
    chk_a("ea_3", 4'h0, 1'b0, 1'b0, ST_RESET);
    adv(252);
    chk_a("ea_hold", 4'h0, 1'b0, 1'b0, ST_RESET);
    a_ext = 1'b1;

    // calibration timeout on the single-channel instance
    reset_b(1'b0);
    chk_b("b_rst", 1'b0, 1'b0, 1'b0, ST_RESET);
    adv(72);
    chk_b("b_wait", 1'b0, 1'b0, 1'b0, ST_WAIT);
    step();
    chk_b("b_tmo", 1'b0, 1'b0, 1'b1, ST_FAULT);
    adv(80);
    chk_b("b_tmo_hold", 1'b0, 1'b0, 1'b1, ST_FAULT);

    // rst mid-RELEASE, then resequence
    reset_b(1'b1);
    adv(9);
    chk_b("b_rel", 1'b0, 1'b0, 1'b0, ST_REL);
    b_rst = 1'b1;
    step();
    chk_b("b_midrst", 1'b0, 1'b0, 1'b0, ST_RESET);
    chk("b_midrst.ready", 32'(b_rdy), 32'(0));
    b_rst = 1'b0;
    cyc = 0;
    adv(9);
    chk_b("b_rs_pre", 1'b0, 1'b0, 1'b0, ST_REL);
    step();
    chk_b("b_rs_ch0", 1'b1, 1'b0, 1'b0, ST_REL);
    step();
    chk_b("b_rs_done", 1'b1, 1'b1, 1'b0, ST_DONE);
    chk("b_rs_done.ready", 32'(b_rdy), 32'(1));
    b_rst = 1'b1;

    // randomized run against the reference model
    reset_a(1'b1);
    m_ph = ST_RESET; m_enter = 0; m_quiet = 0; m_mask = '0;
    eh.delete();
    ext_left = 0;
    for (int t = 0; t < 4000; t++) begin
      if (ext_left > 0) begin
        a_ext = 1'b0;
        ext_left--;
      end else begin
        a_ext = 1'b1;
        if ($urandom_range(0, 399) == 0) ext_left = $urandom_range(1, 6);
      end
      a_cd   = ($urandom_range(0, 499) != 0);
      a_cf   = ($urandom_range(0, 799) == 0);
      a_v    = ($urandom_range(0, 3) == 0);
      a_mask = 4'($urandom);
      chk("rand", 32'({a_st, a_rstn, a_done, a_flt, a_rdy}),
          32'({m_ph, m_rstn(t), m_ph == ST_DONE, m_ph == ST_FAULT,
               m_ph == ST_DONE}));
      eh.push_back(a_ext);
      m_step(t, a_cd, a_cf, a_v, a_mask);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
